// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone command initiator: FSM encoding,
// default bus widths and response status codes.
package wb_master_pkg;

  localparam int WBM_ADDR_W = 32;
  localparam int WBM_DATA_W = 32;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_RESP = 2'd2
  } wbm_state_e;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_ERR = 2'd1,
    RSP_TMO = 2'd2
  } rsp_status_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the limit is reached. TIMEOUT == 0 disables it entirely.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
      logic [CNT_W-1:0] cnt_reg;

      // Saturates at all-ones so a stuck enable can never wrap back to LAST.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else if (en && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign expire = en && (cnt_reg == LAST);
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clr, en};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one bus cycle out, one response
// back. A watchdog terminates cycles the slave never answers.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W  = WBM_ADDR_W,
  parameter int DATA_W  = WBM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [DATA_W-1:0]     cmd_dat_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  busy_o
);

  wbm_state_e  state_reg, state_next;
  rsp_status_e status;
  logic        accept, term, expire, rsp_done;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .clr    (accept),
    .en     (state_reg == WBM_BUS),
    .expire (expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_reg <= WBM_IDLE;
    else            state_reg <= state_next;
  end

  // Error outranks ack, and either outranks the watchdog on the same edge.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    term       = 1'b0;
    status     = RSP_OK;
    case (state_reg)
      WBM_IDLE: begin
        if (cmd_valid_i) begin
          accept     = 1'b1;
          state_next = WBM_BUS;
        end
      end
      WBM_BUS: begin
        if (wbm_err_i) begin
          term   = 1'b1;
          status = RSP_ERR;
        end else if (wbm_ack_i) begin
          term = 1'b1;
        end else if (expire) begin
          term   = 1'b1;
          status = RSP_TMO;
        end
        if (term) state_next = WBM_RESP;
      end
      WBM_RESP: begin
        if (rsp_ready_i) state_next = WBM_IDLE;
      end
      default: state_next = WBM_IDLE;
    endcase
  end

  assign rsp_done    = (state_reg == WBM_RESP) && rsp_ready_i;
  assign cmd_ready_o = (state_reg == WBM_IDLE);
  assign busy_o      = (state_reg != WBM_IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_cyc_o     <= 1'b0;
      wbm_stb_o     <= 1'b0;
      wbm_we_o      <= 1'b0;
      wbm_adr_o     <= '0;
      wbm_dat_o     <= '0;
      wbm_sel_o     <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we_i;
        wbm_adr_o <= cmd_adr_i;
        wbm_dat_o <= cmd_dat_i;
        wbm_sel_o <= cmd_sel_i;
      end
      if (term) begin
        wbm_cyc_o     <= 1'b0;
        wbm_stb_o     <= 1'b0;
        rsp_valid_o   <= 1'b1;
        rsp_err_o     <= (status == RSP_ERR);
        rsp_timeout_o <= (status == RSP_TMO);
        rsp_dat_o     <= (status == RSP_OK && !wbm_we_o) ? wbm_dat_i : '0;
      end
      if (rsp_done) begin
        rsp_valid_o   <= 1'b0;
        rsp_err_o     <= 1'b0;
        rsp_timeout_o <= 1'b0;
        rsp_dat_o     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (TIMEOUT=8): vector table of single
// transactions plus hand sequences for back-pressure, stray acks and reset.
module tb_wb_cmd_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i, busy_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_err_i     (wbm_err_i),
    .busy_o        (busy_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;   // cyc cycle (0-based) on which slave responds; -1 = never
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    int          exp_cyc;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   cyc_cnt;
    logic stable;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    check({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    cmd_adr_i   = 32'h0;
    cmd_dat_i   = 32'h0;
    cyc_cnt     = 0;
    stable      = 1'b1;
    while (wbm_cyc_o === 1'b1 && cyc_cnt < 40) begin
      if (wbm_stb_o !== 1'b1 || wbm_adr_o !== v.adr || wbm_dat_o !== v.dat ||
          wbm_sel_o !== v.sel || wbm_we_o !== v.we || busy_o !== 1'b1)
        stable = 1'b0;
      wbm_dat_i = v.sdat;
      wbm_ack_i = (cyc_cnt == v.ack_at) ? v.ack : 1'b0;
      wbm_err_i = (cyc_cnt == v.ack_at) ? v.err : 1'b0;
      cyc_cnt++;
      @(negedge wb_clk_i);
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = 32'h0;
    check({tag, "_bus_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_cyc_clocks"}, cyc_cnt, v.exp_cyc);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    check({tag, "_rsp_dat"}, rsp_dat_o, v.exp_dat);
    check({tag, "_rsp_err"}, {31'd0, rsp_err_o}, {31'd0, v.exp_err});
    check({tag, "_rsp_tmo"}, {31'd0, rsp_timeout_o}, {31'd0, v.exp_tmo});
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_rsp_clear"}, {30'd0, rsp_valid_o, busy_o}, 32'd0);
    $display("txn %s we=%0d adr=%h cyc=%0d rsp_dat=%h err=%0d tmo=%0d",
             tag, v.we, v.adr, cyc_cnt, v.exp_dat, v.exp_err, v.exp_tmo);
  endtask

  initial begin
    logic [31:0] held_dat;
    int          waited;

    //         we    adr            dat            sel    at  ack   err   sdat           cyc exp_dat        err   tmo
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF,  1, 1'b1, 1'b0, 32'hFFFF_FFFF, 2, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF,  0, 1'b1, 1'b0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, -1, 1'b0, 1'b0, 32'h5555_5555, 8, 32'h0,         1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3,  2, 1'b1, 1'b1, 32'hDEAD_BEEF, 3, 32'h0,         1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h3000_0010, 32'h0BAD_0BAD, 4'h1,  0, 1'b0, 1'b1, 32'h0,         1, 32'h0,         1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h3000_0014, 32'h0,         4'hC,  7, 1'b1, 1'b0, 32'hA5A5_5A5A, 8, 32'hA5A5_5A5A, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h3000_0018, 32'h0,         4'hF,  6, 1'b1, 1'b0, 32'h0F0F_F0F0, 7, 32'h0F0F_F0F0, 1'b0, 1'b0};

    wb_rst_ni   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h0;
    cmd_dat_i   = 32'h0;
    cmd_sel_i   = 4'h0;
    rsp_ready_i = 1'b0;
    wbm_dat_i   = 32'h0;
    wbm_ack_i   = 1'b0;
    wbm_err_i   = 1'b0;

    repeat (2) @(negedge wb_clk_i);
    check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rst_outs", {27'd0, wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_err_o, busy_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stray ack/err while idle must not create a response.
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    repeat (2) @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    check("stray_ack", {29'd0, rsp_valid_o, busy_o, wbm_cyc_o}, 32'd0);
    $display("seq stray_ack idle");

    // Back-pressure: response held while a second command waits.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3000_0020;
    cmd_sel_i   = 4'hF;
    @(negedge wb_clk_i);
    check("bp_cyc1", {31'd0, wbm_cyc_o}, 32'd1);
    cmd_adr_i = 32'h3000_0024;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hFEED_0001;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    held_dat  = 32'hFEED_0001;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k),
            {rsp_dat_o[31:3], cmd_ready_o, rsp_valid_o, wbm_cyc_o},
            {held_dat[31:3], 1'b0, 1'b1, 1'b0});
      check($sformatf("bp_dat%0d", k), rsp_dat_o, held_dat);
      @(negedge wb_clk_i);
    end
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    check("bp_after_hs", {29'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 32'b100);
    @(negedge wb_clk_i);
    check("bp_2nd_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check("bp_2nd_adr", wbm_adr_o, 32'h3000_0024);
    cmd_valid_i = 1'b0;
    wbm_ack_i   = 1'b1;
    wbm_dat_i   = 32'hFEED_0002;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    check("bp_2nd_rsp", rsp_dat_o, 32'hFEED_0002);
    rsp_ready_i = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready_i = 1'b0;
    $display("seq backpressure held 5 cycles, 2nd adr=%h", wbm_adr_o);

    // Reset asserted in the middle of a bus cycle.
    cmd_valid_i = 1'b1;
    cmd_adr_i   = 32'h3000_0030;
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_mid_cyc_pre", {31'd0, wbm_cyc_o}, 32'd1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    check("rst_mid_async", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    wbm_ack_i = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wb_rst_ni = 1'b1;
    waited = 0;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) waited++;
    end
    check("rst_mid_quiet", waited, 0);
    $display("seq reset mid-bus");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
